inst_mem_ctrl: RTL and testbench
================================

# inst_mem_ctrl

Sequencing and arbitration controller for the single-port instruction memory. It shares the memory between two requesters: the IF stage (word reads) and the boot/debug loader (word writes). Arbitration is round-robin, and each access occupies the memory for a fixed latency. The block returns fetched instructions in core byte order and raises `stallreq` toward the pipeline controller while a fetch is outstanding.

## Interface
Parameters:
- `MEM_LATENCY`, default 1: cycles from `mem_ce` high to `mem_rdata` valid; legal range 1..4.
- `MEM_AW`, default 10: memory word-address width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `if_req` in 1: fetch request; held until `if_ack`.
- `if_addr` in 32: fetch byte address; bits [1:0] ignored.
- `if_flush` in 1: branch redirect; kills the in-flight fetch response.
- `if_ack` out 1: one-cycle pulse; `if_inst` valid in the same cycle.
- `if_inst` out 32: fetched instruction.
- `stallreq` out 1: `if_req & ~if_ack` (combinational).
- `ld_req` in 1: loader write request; held until `ld_ack`.
- `ld_addr` in 32: loader byte address; bits [1:0] ignored.
- `ld_wdata` in 32: loader write word.
- `ld_ack` out 1: one-cycle pulse; the write is complete.
- `mem_ce` out 1: memory chip enable, one cycle per access.
- `mem_we` out 1: write enable; only valid while `mem_ce` is high.
- `mem_addr` out `MEM_AW`: word index, equal to `addr[MEM_AW+1:2]`.
- `mem_wdata` out 32: write data to memory.
- `mem_rdata` in 32: read data, valid `MEM_LATENCY` cycles after `mem_ce`.

## Operation
- FSM states:
  - `IDLE`: sample requests. If any request is present, grant one, latch its address and data, and go to `ISSUE`.
  - `ISSUE`: drive `mem_ce`=1, plus `mem_we`=1 for a loader access. Load the wait counter with `MEM_LATENCY`, then go to `WAIT`.
  - `WAIT`: decrement the counter. When it reaches 0, capture `mem_rdata` into the response register and go to `DONE`.
  - `DONE`: pulse the granted port's ack, then go to `IDLE`. Requests are ignored in this state.
- Round-robin grant:
  - If only one port requests, that port wins.
  - If both request, the port not granted last wins.
  - `last_grant` updates on every grant.
- A request still high in the cycle after its ack is treated as a new request.
- Flush:
  - `if_flush` high in any cycle from grant through `DONE` of a fetch sets `kill`.
  - The memory access still completes. In `DONE`, `if_ack` is suppressed and `stallreq` follows `if_req`.
  - `kill` clears on entry to `IDLE`.
  - `if_flush` has no effect on loader transactions.
- `if_inst` holds its last value between acks; it is `ZeroWord` after reset.

## Timing
- Request high in cycle 0 with the FSM in `IDLE`:
  - `mem_ce` is high in cycle 1.
  - `mem_rdata` is captured at the end of cycle `1+MEM_LATENCY`.
  - The ack is high in cycle `2+MEM_LATENCY`.
  - The FSM is back in `IDLE` in cycle `3+MEM_LATENCY`.
- Peak throughput is one access per `3+MEM_LATENCY` cycles.
- Reset values:
  - State `IDLE`.
  - `mem_ce`, `mem_we`, `if_ack`, `ld_ack` = 0.
  - `mem_addr` = 0; `mem_wdata`, `if_inst` = `ZeroWord`.
  - `kill` = 0.
  - `last_grant` = LOADER, so the first tie goes to fetch.
- Reset mid-access: the FSM returns to `IDLE` on the next edge, and no ack is issued for the aborted transaction.
- All `mem_*` outputs are registered. `stallreq` is the only combinational output.

## Configuration
- `INST_BYTE_SWAP_EN` defined:
  - `if_inst = {rdata[7:0], rdata[15:8], rdata[23:16], rdata[31:24]}`.
  - `mem_wdata` is `ld_wdata` with the same byte swap applied, so the memory image stays big-endian per word.
- `INST_BYTE_SWAP_EN` undefined: read and write data pass through unchanged.

## Structure
- Shared defines header `defines.v`:
  - `ZeroWord`, `ChipEnable`, `ChipDisable`, `InstAddrBus`, `InstBus`.
  - New FSM state encodings `MemCtrlIdle`, `MemCtrlIssue`, `MemCtrlWait`, `MemCtrlDone`.
  - Grant encodings `GrantFetch`, `GrantLoader`.
- One sub-module, `rr_arb2`: 2-way round-robin arbiter.
  - Inputs: `clk`, `rst`, `req[1:0]`, `advance`.
  - Outputs: one-hot `gnt[1:0]` and the `last_grant` register.
- The FSM, wait counter and byte-swap logic live in `inst_mem_ctrl`.

## Test plan
- Single fetch: `MEM_LATENCY`=1, `if_addr`=0x8, memory word 2 = 0x13050000, swap enabled -> `mem_ce` high in cycle 1 with `mem_addr`=2; `if_ack` in cycle 3 with `if_inst`=0x00000513; `stallreq` high in cycles 0–2.
- Loader write then read-back: `ld_addr`=0x10, `ld_wdata`=0xDEADBEEF -> `mem_we`=1 with `mem_addr`=4 and `mem_wdata`=0xEFBEADDE (swap enabled); a later fetch of 0x10 returns 0xDEADBEEF.
- Tie arbitration: `if_req` and `ld_req` both high out of reset -> fetch granted first and loader second; the next tie after that is granted to fetch.
- Flush in `WAIT` (`MEM_LATENCY`=3): assert `if_flush` for one cycle in cycle 3 -> no `if_ack`; the FSM reaches `IDLE` in cycle 6; a new fetch is then served normally.
- Reset mid-access: `rst` high in cycle 2 of a loader write -> no `ld_ack`; `mem_ce`=0 and all outputs at reset values in the following cycle.
- Swap disabled build: memory word 0x11223344 -> `if_inst`=0x11223344.

Source files
------------

// File: rtl/inst_mem_ctrl_pkg.sv
// inst_mem_ctrl_pkg: shared constants, FSM/grant encodings and byte-swap helper for the instruction memory controller
package inst_mem_ctrl_pkg;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  localparam logic ChipEnable = 1'b1;
  localparam logic ChipDisable = 1'b0;
  localparam int InstAddrBus = 32;
  localparam int InstBus = 32;
  localparam logic [1:0] MemCtrlIdle = 2'd0;
  localparam logic [1:0] MemCtrlIssue = 2'd1;
  localparam logic [1:0] MemCtrlWait = 2'd2;
  localparam logic [1:0] MemCtrlDone = 2'd3;
  localparam logic GrantFetch = 1'b0;
  localparam logic GrantLoader = 1'b1;
  function automatic logic [InstBus-1:0] bswap(input logic [InstBus-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
endpackage

// File: rtl/inst_mem_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; bit 0 is fetch, bit 1 is loader
module rr_arb2
  import inst_mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       last_grant
);
  always_comb begin
    gnt[0] = req[0] & (~req[1] | (last_grant == GrantLoader));
    gnt[1] = req[1] & (~req[0] | (last_grant == GrantFetch));
  end
  always_ff @(posedge clk)
    if (rst) last_grant <= GrantLoader;
    else if (advance && |req) last_grant <= gnt[1] ? GrantLoader : GrantFetch;
endmodule

// File: rtl/inst_mem_ctrl.sv
// inst_mem_ctrl: round-robin sequencer sharing the instruction memory between fetch and loader
// INST_BYTE_SWAP_EN: byte-swap fetched instructions and loader write data
module inst_mem_ctrl
  import inst_mem_ctrl_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int MEM_AW = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_req,
  input  logic [InstAddrBus-1:0] if_addr,
  input  logic                   if_flush,
  output logic                   if_ack,
  output logic [InstBus-1:0]     if_inst,
  output logic                   stallreq,
  input  logic                   ld_req,
  input  logic [InstAddrBus-1:0] ld_addr,
  input  logic [InstBus-1:0]     ld_wdata,
  output logic                   ld_ack,
  output logic                   mem_ce,
  output logic                   mem_we,
  output logic [MEM_AW-1:0]      mem_addr,
  output logic [InstBus-1:0]     mem_wdata,
  input  logic [InstBus-1:0]     mem_rdata
);
  logic [1:0] state;
  logic [2:0] cnt;
  logic grant_ld, kill, last_grant;
  logic [1:0] gnt;
  logic [InstBus-1:0] ld_word, rd_word;
  logic unused;
  assign unused = ^{if_addr[1:0], if_addr[InstAddrBus-1:MEM_AW+2], ld_addr[1:0], ld_addr[InstAddrBus-1:MEM_AW+2], last_grant};
`ifdef INST_BYTE_SWAP_EN
  assign ld_word = bswap(ld_wdata);
  assign rd_word = bswap(mem_rdata);
`else
  assign ld_word = ld_wdata;
  assign rd_word = mem_rdata;
`endif
  assign stallreq = if_req & ~if_ack;
  rr_arb2 u_arb (
    .clk(clk),
    .rst(rst),
    .req({ld_req, if_req}),
    .advance(state == MemCtrlIdle),
    .gnt(gnt),
    .last_grant(last_grant)
  );
  // a flush in the final WAIT cycle must still suppress the registered ack
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MemCtrlIdle;
      cnt <= '0;
      grant_ld <= GrantFetch;
      kill <= 1'b0;
      mem_ce <= ChipDisable;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= ZeroWord;
      if_inst <= ZeroWord;
      if_ack <= 1'b0;
      ld_ack <= 1'b0;
    end else begin
      mem_ce <= ChipDisable;
      mem_we <= 1'b0;
      if_ack <= 1'b0;
      ld_ack <= 1'b0;
      if (if_flush && !grant_ld && state != MemCtrlIdle) kill <= 1'b1;
      case (state)
        MemCtrlIdle:
          if (|gnt) begin
            grant_ld <= gnt[1];
            mem_addr <= gnt[1] ? ld_addr[MEM_AW+1:2] : if_addr[MEM_AW+1:2];
            if (gnt[1]) mem_wdata <= ld_word;
            mem_ce <= ChipEnable;
            mem_we <= gnt[1];
            kill <= gnt[0] & if_flush;
            state <= MemCtrlIssue;
          end
        MemCtrlIssue: begin
          cnt <= 3'(MEM_LATENCY);
          state <= MemCtrlWait;
        end
        MemCtrlWait: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state <= MemCtrlDone;
            ld_ack <= grant_ld;
            if_ack <= ~grant_ld & ~(kill | if_flush);
            if (!grant_ld && !(kill || if_flush)) if_inst <= rd_word;
          end
        end
        default: begin
          state <= MemCtrlIdle;
          kill <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_inst_mem_ctrl.sv
// tb_inst_mem_ctrl: transaction-schedule model plus directed vectors for inst_mem_ctrl
module tb_inst_mem_ctrl;
  localparam int LAT = 3;
  logic clk = 1'b0, rst = 1'b1;
  logic if_req = 0, if_flush = 0, ld_req = 0;
  logic [31:0] if_addr = 0, ld_addr = 0, ld_wdata = 0;
  logic if_ack, ld_ack, stallreq, mem_ce, mem_we;
  logic [31:0] if_inst, mem_wdata, mem_rdata;
  logic [9:0] mem_addr;
  int pass_cnt = 0, total_cnt = 0;

  inst_mem_ctrl #(.MEM_LATENCY(LAT), .MEM_AW(10)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ack(if_ack), .if_inst(if_inst), .stallreq(stallreq), .ld_req(ld_req),
    .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack), .mem_ce(mem_ce),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] swp(input logic [31:0] w);
`ifdef INST_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // memory with a LAT-deep read pipeline
  logic [31:0] mem [0:1023];
  logic [31:0] pipe [0:LAT-1];
  logic mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      mem[0] <= 32'h1122_3344;
      mem[2] <= 32'h1305_0000;
      mem_init <= 1'b1;
    end else if (mem_ce && mem_we) mem[mem_addr] <= mem_wdata;
    pipe[0] <= mem[mem_addr];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[LAT-1];

  // model: each granted access runs t = 1 .. 2+LAT cycles after its grant
  logic [31:0] m_mem [0:1023];
  logic [31:0] m_inst, m_wdata;
  logic [9:0] m_addr;
  logic m_valid = 0, m_busy = 0, m_ld = 0, m_kill = 0, m_last = 1;
  int m_t = 0;
  initial begin
    logic e_ce, e_done;
    m_mem[0] = 32'h1122_3344;
    m_mem[2] = 32'h1305_0000;
    m_inst = 0;
    m_wdata = 0;
    m_addr = 0;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        e_ce = m_busy && m_t == 1;
        e_done = m_busy && m_t == 2 + LAT;
        chk("mem_ce", mem_ce, e_ce);
        chk("mem_we", mem_we, e_ce && m_ld);
        chk("if_ack", if_ack, e_done && !m_ld && !m_kill);
        chk("ld_ack", ld_ack, e_done && m_ld);
        chk("stallreq", stallreq, if_req && !(e_done && !m_ld && !m_kill));
        chk("if_inst", if_inst, m_inst);
        if (e_ce) chk("mem_addr", mem_addr, m_addr);
        if (e_ce && m_ld) chk("mem_wdata", mem_wdata, swp(m_wdata));
      end
      if (rst) begin
        m_valid = 1; m_busy = 0; m_kill = 0; m_last = 1; m_inst = 0;
      end else if (m_valid) begin
        if (m_busy) begin
          if (if_flush && !m_ld) m_kill = 1;
          if (m_t == 1 && m_ld) m_mem[m_addr] = swp(m_wdata);
          if (m_t == 1 + LAT && !m_ld && !m_kill) m_inst = swp(m_mem[m_addr]);
          if (m_t == 2 + LAT) begin m_busy = 0; m_kill = 0; end
          else m_t++;
        end else if (if_req || ld_req) begin
          m_ld = (if_req && ld_req) ? !m_last : ld_req;
          m_last = m_ld;
          m_busy = 1;
          m_t = 1;
          m_addr = m_ld ? ld_addr[11:2] : if_addr[11:2];
          m_wdata = ld_wdata;
          m_kill = !m_ld && if_flush;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] exp_inst);
    int n = 0;
    if_addr = a;
    if_req = 1;
    while (!if_ack && n < 40) begin
      if (n == 1) begin
        chk("fetch_ce", mem_ce, 1);
        chk("fetch_addr", mem_addr, {22'b0, a[11:2]});
      end
      tick();
      n++;
    end
    if_req = 0;
    chk("fetch_lat", n, 2 + LAT);
    chk("fetch_inst", if_inst, exp_inst);
    tick();
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_w);
    int n = 0;
    ld_addr = a;
    ld_wdata = d;
    ld_req = 1;
    while (!ld_ack && n < 40) begin
      if (n == 1) begin
        chk("ld_we", mem_we, 1);
        chk("ld_addr", mem_addr, {22'b0, a[11:2]});
        chk("ld_wdata", mem_wdata, exp_w);
      end
      tick();
      n++;
    end
    ld_req = 0;
    chk("ld_lat", n, 2 + LAT);
    tick();
  endtask

  task automatic tie();
    int n = 0, fa = -1, la = -1;
    if_addr = 32'h8;
    ld_addr = 32'h40;
    ld_wdata = 32'hCAFE_F00D;
    if_req = 1;
    ld_req = 1;
    while ((fa < 0 || la < 0) && n < 40) begin
      if (if_ack) begin fa = n; if_req = 0; end
      if (ld_ack) begin la = n; ld_req = 0; end
      tick();
      n++;
    end
    if_req = 0;
    ld_req = 0;
    chk("tie_fetch_first", fa, 2 + LAT);
    chk("tie_loader_second", la, (3 + LAT) + (2 + LAT));
  endtask

  task automatic reset_pulse();
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    int fa, ce2, acks;
    logic [31:0] e8, e0, ew;
    e8 = swp(32'h1305_0000);
    e0 = swp(32'h1122_3344);
    ew = swp(32'hDEAD_BEEF);
`ifdef INST_BYTE_SWAP_EN
    chk("lit_swap_inst", e8, 32'h0000_0513);
    chk("lit_swap_wdata", ew, 32'hEFBE_ADDE);
`else
    chk("lit_pass_inst", e0, 32'h1122_3344);
`endif
    tick();
    tick();
    chk("rst_ce", mem_ce, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_inst", if_inst, 0);
    chk("rst_acks", {if_ack, ld_ack}, 0);
    rst = 0;
    fetch(32'h8, e8);
    load(32'h10, 32'hDEAD_BEEF, ew);
    fetch(32'h10, 32'hDEAD_BEEF);
    fetch(32'h0, e0);
    reset_pulse();
    tie();
    tie();
    // flush during WAIT with the request held: killed, then re-served
    fa = -1; ce2 = -1;
    if_addr = 32'h8;
    if_req = 1;
    for (int n = 0; n < 40 && fa < 0; n++) begin
      if_flush = (n == 3);
      if (if_ack) begin fa = n; if_req = 0; end
      if (mem_ce && n > 1 && ce2 < 0) ce2 = n;
      tick();
    end
    if_flush = 0;
    if_req = 0;
    chk("flush_reissue_ce", ce2, 4 + LAT);
    chk("flush_ack", fa, (3 + LAT) + (2 + LAT));
    chk("flush_inst", if_inst, e8);
    tick();
    // reset in cycle 2 of a loader write
    ld_addr = 32'h20;
    ld_wdata = 32'h5555_AAAA;
    ld_req = 1;
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    ld_req = 0;
    chk("mid_rst_ce", mem_ce, 0);
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_wdata", mem_wdata, 0);
    chk("mid_rst_inst", if_inst, 0);
    acks = 0;
    for (int n = 0; n < 10; n++) begin
      acks += int'(ld_ack) + int'(if_ack);
      tick();
    end
    chk("mid_rst_no_ack", acks, 0);
    fetch(32'h8, e8);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
